// File: rtl/hack_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// hack_mem_pkg
// Shared definitions for the Hack data-RAM arbiter: default bus widths,
// the starvation-counter width and the arbiter state encoding.
// -----------------------------------------------------------------------------
package hack_mem_pkg;

    localparam int ADDR_W_DEFAULT = 15;
    localparam int DATA_W_DEFAULT = 16;

    // wait_cnt is 4 bits wide, which bounds MAX_WAIT to 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        CPU_PRI   = 2'd0,  // CPU owns the port, host fills idle cycles
        HOST_TURN = 2'd1,  // host is owed one slot after losing MAX_WAIT times
        LOCKED    = 2'd2   // host holds the port for a bulk transfer
    } arb_state_t;

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// hack_mem_arbiter_if
// Bundles the three sides of the arbiter: the Hack CPU data port, the host
// (loader / debug / DMA) port and the single-port RAM port.
//   slave  : view of the arbiter itself
//   master : view of the surrounding system (CPU, host and RAM instance)
// CPU   : cpu_access, cpu_addr, cpu_wdata, cpu_we -> ; <- cpu_rdata, cpu_hold
// Host  : host_req, host_lock, host_we, host_addr, host_wdata ->
//         <- host_gnt, host_rvalid, host_rdata
// RAM   : <- ram_addr, ram_wdata, ram_we ; ram_rdata ->
// -----------------------------------------------------------------------------
interface hack_mem_arbiter_if #(
    parameter int ADDR_W = hack_mem_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W = hack_mem_pkg::DATA_W_DEFAULT
);

    logic              cpu_access;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_hold;

    logic              host_req;
    logic              host_lock;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_access, cpu_addr, cpu_wdata, cpu_we,
        output cpu_rdata, cpu_hold,
        input  host_req, host_lock, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output cpu_access, cpu_addr, cpu_wdata, cpu_we,
        input  cpu_rdata, cpu_hold,
        output host_req, host_lock, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

// File: rtl/hack_mem_arbiter_wait_counter.sv
// -----------------------------------------------------------------------------
// hack_wait_counter
// Counts consecutive conflict cycles lost by the host. Clear has priority
// over increment; the count saturates at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : return the count to 0
//   i_inc      : add one (ignored when i_clr is set)
//   o_term     : count equals MAX_WAIT-1, i.e. this conflict is the last one
// -----------------------------------------------------------------------------
module hack_wait_counter
    import hack_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, regardless of the
    // order in which the simulator evaluates the always blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_term = (r_cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/hack_mem_arbiter.sv
// -----------------------------------------------------------------------------
// hack_mem_arbiter
// Shares the Hack single-port data RAM between the CPU data port and a host
// port. The CPU has priority; after MAX_WAIT lost conflicts the host is given
// one forced slot. A granted host access with host_lock=1 freezes the CPU
// until host_lock drops.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hack_mem_arbiter_if.slave (CPU, host and RAM ports)
// cpu_hold, host_gnt and ram_* are combinational from state and requests;
// host_rvalid / host_rdata are registered one cycle after a host read grant.
// -----------------------------------------------------------------------------
module hack_mem_arbiter
    import hack_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hack_mem_arbiter_if.slave    bus
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic              w_host_gnt;
    logic              w_cpu_hold;
    logic              w_conflict;
    logic              w_term;
    logic              w_cnt_inc;
    logic              w_host_rd;

    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic              w_ram_we;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CPU_PRI;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        w_next_state = CPU_PRI;
        unique case (r_state)
            CPU_PRI: begin
                if (w_host_gnt && bus.host_lock) begin
                    w_next_state = LOCKED;
                end else if (w_conflict && w_term) begin
                    w_next_state = HOST_TURN;
                end
            end
            HOST_TURN: begin
                // One slot only; a dropped request simply forfeits it.
                if (w_host_gnt && bus.host_lock) begin
                    w_next_state = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.host_lock) begin
                    w_next_state = LOCKED;
                end
            end
            default: w_next_state = CPU_PRI;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_host_gnt = 1'b0;
        w_cpu_hold = 1'b0;
        unique case (r_state)
            CPU_PRI: begin
                w_host_gnt = bus.host_req && !bus.cpu_access;
            end
            HOST_TURN: begin
                w_host_gnt = bus.host_req;
                w_cpu_hold = bus.host_req && bus.cpu_access;
            end
            LOCKED: begin
                w_host_gnt = bus.host_req;
                w_cpu_hold = 1'b1;
            end
            default: begin
                w_host_gnt = 1'b0;
                w_cpu_hold = 1'b0;
            end
        endcase
    end

    // A conflict is only counted while the CPU holds priority; any other
    // cycle (including the forced host slot) restarts the count from 0.
    assign w_conflict = (r_state == CPU_PRI) && bus.host_req && bus.cpu_access;
    assign w_cnt_inc  = w_conflict && !w_term;

    hack_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!w_cnt_inc),
        .i_inc  (w_cnt_inc),
        .o_term (w_term)
    );

    // ------------------------------------------------------------- port mux
    // A held CPU must never write; the host side wins the address whenever
    // it is granted, otherwise the CPU address is presented for its read.
    always_comb begin
        if (w_host_gnt) begin
            w_ram_addr  = bus.host_addr;
            w_ram_wdata = bus.host_wdata;
            w_ram_we    = bus.host_we;
        end else begin
            w_ram_addr  = bus.cpu_addr;
            w_ram_wdata = bus.cpu_wdata;
            w_ram_we    = bus.cpu_access && bus.cpu_we && !w_cpu_hold;
        end
    end

    // ------------------------------------------------------- host read data
    assign w_host_rd = w_host_gnt && !bus.host_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_host_rvalid <= w_host_rd;
            if (w_host_rd) begin
                r_host_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr    = w_ram_addr;
    assign bus.ram_wdata   = w_ram_wdata;
    assign bus.ram_we      = w_ram_we;
    assign bus.cpu_rdata   = bus.ram_rdata;
    assign bus.cpu_hold    = w_cpu_hold;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_hack_mem_arbiter
// Directed scenarios followed by randomized CPU/host traffic. The bench owns a
// 16-word RAM model attached to the arbiter's RAM port and a reference model
// that tracks arbitration as "losses in a row", "host slot owed" and "locked",
// plus a golden copy of memory contents.
// -----------------------------------------------------------------------------
module tb_hack_mem_arbiter;
    import hack_mem_pkg::*;

    localparam int AW       = ADDR_W_DEFAULT;
    localparam int DW       = DATA_W_DEFAULT;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hack_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    hack_mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Attached RAM: asynchronous read, synchronous write, 16 words.
    logic [DW-1:0] ram [16];
    logic          ram_clr = 1'b1;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else if (bus.ram_we) begin
            ram[bus.ram_addr[3:0]] <= bus.ram_wdata;
        end
    end
    assign bus.ram_rdata = ram[bus.ram_addr[3:0]];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------- reference model
    bit            m_locked;
    bit            m_turn;
    int            m_loss;
    logic [DW-1:0] gold [16];
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    logic          e_gnt, e_hold, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_reset();
        m_locked = 0;
        m_turn   = 0;
        m_loss   = 0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Evaluate the combinational side mid-cycle and compare.
    task automatic eval_cycle();
        @(negedge clk);
        if (m_locked) begin
            e_gnt  = bus.host_req;
            e_hold = 1'b1;
        end else if (m_turn) begin
            e_gnt  = bus.host_req;
            e_hold = bus.host_req & bus.cpu_access;
        end else begin
            e_gnt  = bus.host_req & ~bus.cpu_access;
            e_hold = 1'b0;
        end
        e_addr  = e_gnt ? bus.host_addr  : bus.cpu_addr;
        e_wdata = e_gnt ? bus.host_wdata : bus.cpu_wdata;
        e_we    = e_gnt ? bus.host_we    : (bus.cpu_access & bus.cpu_we & ~e_hold);
        check("host_gnt", bus.host_gnt, e_gnt);
        check("cpu_hold", bus.cpu_hold, e_hold);
        check("ram_we",   bus.ram_we,   e_we);
        check("ram_addr", bus.ram_addr, e_addr);
        if (e_we) check("ram_wdata", bus.ram_wdata, e_wdata);
        if (bus.cpu_access && !e_hold && !e_gnt && !bus.cpu_we)
            check("cpu_rdata", bus.cpu_rdata, gold[bus.cpu_addr[3:0]]);
    endtask

    // Advance one edge, update the model, then compare the registered side.
    task automatic advance();
        bit conflict;
        @(posedge clk);
        conflict = !m_locked && !m_turn && bus.host_req && bus.cpu_access;
        m_rvalid = e_gnt & ~bus.host_we;
        if (m_rvalid) m_rdata = gold[bus.host_addr[3:0]];
        if (e_we) gold[e_addr[3:0]] = e_wdata;
        m_locked = m_locked ? bus.host_lock : (e_gnt & bus.host_lock);
        if (conflict) begin
            m_loss++;
            if (m_loss == MAX_WAIT) begin
                m_turn = 1;
                m_loss = 0;
            end
        end else begin
            m_loss = 0;
            m_turn = 0;
        end
        #1;
        check("host_rvalid", bus.host_rvalid, m_rvalid);
        check("host_rdata",  bus.host_rdata,  m_rdata);
    endtask

    task automatic set_cpu(input logic acc, input logic we, input int addr, input logic [DW-1:0] d);
        bus.cpu_access = acc;
        bus.cpu_we     = we;
        bus.cpu_addr   = AW'(addr);
        bus.cpu_wdata  = d;
    endtask

    task automatic set_host(input logic req, input logic lock, input logic we, input int addr,
                            input logic [DW-1:0] d);
        bus.host_req   = req;
        bus.host_lock  = lock;
        bus.host_we    = we;
        bus.host_addr  = AW'(addr);
        bus.host_wdata = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pending;

        set_cpu(0, 0, 0, '0);
        set_host(0, 0, 0, 0, '0);
        model_reset();
        for (int i = 0; i < 16; i++) gold[i] = '0;

        // Reset state.
        #1;
        check("rst_cpu_hold",    bus.cpu_hold,    1'b0);
        check("rst_host_gnt",    bus.host_gnt,    1'b0);
        check("rst_host_rvalid", bus.host_rvalid, 1'b0);
        check("rst_host_rdata",  bus.host_rdata,  '0);
        check("rst_ram_we",      bus.ram_we,      1'b0);
        repeat (2) @(posedge clk);
        #1 ram_clr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Host-only write then read.
        set_host(1, 0, 1, 5, 16'h1234);
        eval_cycle();
        check("t1_wr_gnt", bus.host_gnt, 1'b1);
        advance();
        set_host(1, 0, 0, 5, '0);
        eval_cycle();
        check("t1_rd_gnt", bus.host_gnt, 1'b1);
        advance();
        check("t1_rvalid", bus.host_rvalid, 1'b1);
        check("t1_rdata",  bus.host_rdata,  16'h1234);
        set_host(0, 0, 0, 0, '0);

        // CPU write then combinational read.
        set_cpu(1, 1, 2, 16'h00FF);
        eval_cycle();
        check("t2_ram_we",   bus.ram_we,   1'b1);
        check("t2_ram_addr", bus.ram_addr, 2);
        check("t2_hold",     bus.cpu_hold, 1'b0);
        advance();
        set_cpu(1, 0, 2, '0);
        eval_cycle();
        check("t2_cpu_rdata", bus.cpu_rdata, 16'h00FF);
        advance();

        // Starvation: host forced in on every 5th cycle.
        for (int i = 0; i < 10; i++) begin
            set_cpu(1, 0, 3, '0);
            set_host(1, 0, 1, 9, DW'(16'h5A00 + i / 5));
            eval_cycle();
            check("t3_gnt",  bus.host_gnt, (i % 5) == 4);
            check("t3_hold", bus.cpu_hold, (i % 5) == 4);
            advance();
        end
        set_host(0, 0, 0, 0, '0);

        // Lock burst: 8 writes to 0..7, last one with host_lock=0.
        set_cpu(0, 0, 0, '0);
        set_host(1, 1, 1, 0, 16'hA000);
        eval_cycle();
        check("t4_first_gnt", bus.host_gnt, 1'b1);
        advance();
        for (int i = 1; i < 8; i++) begin
            set_cpu(1, 1, 12, 16'hDEAD);
            set_host(1, i != 7, 1, i, DW'(16'hA000 + i));
            eval_cycle();
            check("t4_gnt",  bus.host_gnt, 1'b1);
            check("t4_hold", bus.cpu_hold, 1'b1);
            check("t4_addr", bus.ram_addr, i);
            advance();
        end
        set_host(0, 0, 0, 0, '0);
        set_cpu(1, 1, 12, 16'hBEEF);
        eval_cycle();
        check("t4_unlock_hold", bus.cpu_hold, 1'b0);
        check("t4_unlock_we",   bus.ram_we,   1'b1);
        advance();
        set_cpu(0, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            set_host(1, 0, 0, i, '0);
            eval_cycle();
            advance();
            check("t4_readback", bus.host_rdata, DW'(16'hA000 + i));
        end
        set_host(0, 0, 0, 0, '0);

        // Reset in the cycle after a host read grant.
        set_host(1, 0, 0, 5, '0);
        eval_cycle();
        advance();
        set_host(0, 0, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        check("t5_rvalid", bus.host_rvalid, 1'b0);
        check("t5_rdata",  bus.host_rdata,  '0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_cpu(1, 0, 4, '0);
        set_host(1, 0, 0, 6, '0);
        eval_cycle();
        check("t5_cpu_pri_gnt",  bus.host_gnt, 1'b0);
        check("t5_cpu_pri_hold", bus.cpu_hold, 1'b0);
        advance();
        set_host(0, 0, 0, 0, '0);
        eval_cycle();
        advance();

        // Lock request while the CPU is busy: CPU wins, then lock is taken.
        for (int i = 0; i <= MAX_WAIT; i++) begin
            set_cpu(1, 0, 1, '0);
            set_host(1, 1, 0, 2, '0);
            eval_cycle();
            check("t6_gnt",  bus.host_gnt, i == MAX_WAIT);
            check("t6_hold", bus.cpu_hold, i == MAX_WAIT);
            advance();
        end
        set_host(1, 1, 1, 9, 16'h7777);
        eval_cycle();
        check("t6_locked_gnt",  bus.host_gnt, 1'b1);
        check("t6_locked_hold", bus.cpu_hold, 1'b1);
        advance();
        set_host(0, 0, 0, 0, '0);
        eval_cycle();
        check("t6_exit_hold", bus.cpu_hold, 1'b1);
        check("t6_exit_gnt",  bus.host_gnt, 1'b0);
        advance();
        eval_cycle();
        check("t6_after_hold", bus.cpu_hold, 1'b0);
        advance();

        // Randomized traffic; host holds each request until granted.
        pending = 0;
        for (int n = 0; n < 3000; n++) begin
            set_cpu(($urandom % 10) < 7, $urandom % 2, $urandom % 16, DW'($urandom));
            if (!pending) begin
                if ($urandom % 3 == 0) begin
                    set_host(1, m_locked ? ($urandom % 8 != 0) : ($urandom % 8 == 0),
                             $urandom % 2, $urandom % 16, DW'($urandom));
                    pending = 1;
                end else begin
                    set_host(0, m_locked && ($urandom % 8 != 0), 0, 0, '0);
                end
            end
            eval_cycle();
            if (e_gnt) pending = 0;
            advance();
            if (!pending) bus.host_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Two-port arbiter that shares the single-port data RAM between the Hack CPU data port and a host port used for program/data loading, debug peek/poke and I/O DMA. It sits between the CPU's `ramAddr`/`ramDout`/`ramStore`/`ramDin` signals and the RAM instance. The CPU has priority, but a starvation counter forces a host slot after `MAX_WAIT` lost conflicts. A lock mode holds the CPU for bulk host transfers.

## Interface
- `ADDR_W`, 15, RAM word-address width
- `DATA_W`, 16, data width
- `MAX_WAIT`, 4, consecutive conflict cycles the CPU may win before the host is forced in; legal range 1..15
- `clk` input 1: single clock, all state on posedge
- `rst_n` input 1: asynchronous, active-low reset
- `cpu_access` input 1: CPU needs RAM this cycle (M read or M write)
- `cpu_addr` input ADDR_W: CPU address (A[1:15])
- `cpu_wdata` input DATA_W: CPU write data (ALU output)
- `cpu_we` input 1: CPU write strobe
- `cpu_rdata` output DATA_W: RAM read data to CPU, combinational
- `cpu_hold` output 1: freeze PC, A and D this cycle
- `host_req` input 1: host request; held until `host_gnt`
- `host_lock` input 1: sampled with `host_req`; requests exclusive ownership
- `host_we` input 1: host write
- `host_addr` input ADDR_W: host address
- `host_wdata` input DATA_W: host write data
- `host_gnt` output 1: host access performed this cycle
- `host_rvalid` output 1: registered; `host_rdata` is valid
- `host_rdata` output DATA_W: registered host read data
- `ram_addr` output ADDR_W, `ram_wdata` output DATA_W, `ram_we` output 1: RAM write/read port
- `ram_rdata` input DATA_W: RAM asynchronous read data

## Operation
- States: `CPU_PRI` (reset), `HOST_TURN`, `LOCKED`. `wait_cnt` is a 4-bit counter with reset value 0.
- In `CPU_PRI`:
  - `host_req & ~cpu_access`: grant the host. `wait_cnt` clears to 0.
  - `host_req & cpu_access`: the CPU wins and `wait_cnt` increments. If `wait_cnt == MAX_WAIT-1`, the next state is `HOST_TURN` and `wait_cnt` clears.
  - `~host_req`: `wait_cnt` clears to 0.
- In `HOST_TURN`:
  - With `host_req`, the host is granted and `cpu_hold = cpu_access`.
  - The next state is always `CPU_PRI`.
  - If `host_req` has dropped (protocol violation), there is no grant and the state returns to `CPU_PRI`.
- Entering `LOCKED`: any cycle in which the host is granted with `host_lock=1` moves the next state to `LOCKED`.
- In `LOCKED`:
  - `cpu_hold=1` unconditionally.
  - `host_gnt = host_req` on every cycle.
  - When `host_lock=0`, the next state is `CPU_PRI`, and this cycle's request (if any) is still granted.
- Port mux:
  - Granted side drives `ram_addr`, `ram_wdata` and `ram_we`.
  - With no grant: `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`, `ram_we=0`.
  - When the CPU is held: `ram_we=0`.
- `cpu_rdata = ram_rdata` at all times. The CPU ignores it while `cpu_hold=1`.
- A host read is a granted cycle with `host_we=0`. On the next edge, `host_rdata <= ram_rdata` and `host_rvalid <= 1` for one cycle.
- On a host write, `host_rvalid` stays 0.
- Outputs at reset: `cpu_hold=0`, `host_gnt=0`, `host_rvalid=0`, `host_rdata=0`, `ram_we=0`.

## Timing
- Outputs `cpu_hold`, `host_gnt` and the ram_* signals are combinational from state and inputs, with no added latency. A CPU access completes in the same cycle.
- Host latency:
  - Write: 0 cycles after grant.
  - Read: data arrives 1 cycle after `host_gnt`.
- Worst-case host wait with the CPU accessing every cycle is `MAX_WAIT+1` cycles from `host_req` to `host_gnt`.
- `host_req` may stay high after a grant for a back-to-back access on the next cycle, subject to the same arbitration.
- Reset mid-operation clears state, `wait_cnt` and any pending `host_rvalid` immediately. The host must re-issue the request.
- No combinational path from `ram_rdata` to any control output.

## Structure
- Package `hack_mem_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults
  - `arb_state_t` enum {`CPU_PRI`, `HOST_TURN`, `LOCKED`}
- Sub-module `hack_wait_counter`: saturating counter with clear, increment and a terminal flag at `MAX_WAIT-1`.
- Everything else stays in `hack_mem_arbiter`.

## Test plan
- **Host-only write/read:** with `cpu_access=0`, host writes 0x1234 to 5, then reads 5. Required: `host_gnt` in the same cycle for both; one cycle after the read grant, `host_rvalid=1` and `host_rdata=0x1234`.
- **CPU priority:** CPU writes 0x00FF to 2 with `host_req` idle. Required: `ram_we=1`, `ram_addr=2`, `cpu_hold=0`; a following CPU read of 2 returns 0x00FF combinationally.
- **Starvation:** `cpu_access=1` every cycle and `host_req=1`, with `MAX_WAIT=4`. Required: the CPU wins 4 cycles, the host is granted on the 5th with `cpu_hold=1`, then the CPU wins again and `wait_cnt` restarts at 0.
- **Lock burst:** host grant with `host_lock=1`, then 8 writes to 0..7 while `cpu_access=1`. Required: `cpu_hold=1` throughout and RAM[0..7] written. The cycle with `host_lock=0` is still granted; the following cycle returns to `CPU_PRI` with `cpu_hold=0`.
- **Reset during read:** assert `rst_n=0` in the cycle after a host read grant, before the edge. Required: `host_rvalid=0` and `host_rdata=0` immediately, with the state in `CPU_PRI`.
- **Simultaneous lock and CPU access:** `host_req` and `host_lock` asserted while `cpu_access=1` and `wait_cnt=0`. Required: the CPU wins and the lock is not taken; after `MAX_WAIT` cycles the host is granted and the state enters `LOCKED`.
